// File: rtl/gate_encoder_if.sv
// gate_encoder_if: record-in / byte-out bus of the gate record serializer.
//   in_valid/in_ready     record handshake (gate_type, id_1, id_2, ctxt, gate_id)
//   out_data/out_valid/out_ready  byte handshake toward the SPI transmit shifter
//   done                  one-cycle pulse after the last byte of a record
// master: record producer / byte consumer.  slave: the encoder.
interface gate_encoder_if #(
  parameter int ID_W     = 24,
  parameter int CTXT_W   = 128,
  parameter int NUM_CTXT = 3
);
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 gate_type;
  logic [ID_W-1:0]            id_1;
  logic [ID_W-1:0]            id_2;
  logic [NUM_CTXT*CTXT_W-1:0] ctxt;
  logic [ID_W-1:0]            gate_id;
  logic [7:0]                 out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       done;

  modport master (
    output in_valid, gate_type, id_1, id_2, ctxt, gate_id, out_ready,
    input  in_ready, out_data, out_valid, done
  );

  modport slave (
    input  in_valid, gate_type, id_1, id_2, ctxt, gate_id, out_ready,
    output in_ready, out_data, out_valid, done
  );
endinterface

// File: rtl/gate_encoder.sv
// gate_encoder: serializes one parallel gate record into the spi_decoder byte
// stream (type, id_1, id_2, ciphertexts, gate_id; multi-byte fields LSB first).
//   clk, rst  clock and synchronous active-high reset
//   bus       gate_encoder_if.slave (record in, byte stream out, done pulse)
//
// state  | meaning
// IDLE   | waiting for a record, in_ready high
// TYPE   | sending {6'b0, gate_type}
// ID1    | sending id_1 bytes
// ID2    | sending id_2 bytes (not for BUF)
// CTXT   | sending ciphertext bytes (AND only)
// GID    | sending gate_id bytes
module gate_encoder #(
  parameter int ID_W     = 24,
  parameter int CTXT_W   = 128,
  parameter int NUM_CTXT = 3
) (
  input  logic           clk,
  input  logic           rst,
  gate_encoder_if.slave  bus
);
  localparam int ID_B = ID_W / 8;
  localparam int CT_B = CTXT_W / 8;
  localparam int BI_W = (ID_B > 1) ? $clog2(ID_B) : 1;
  localparam int CB_W = (CT_B > 1) ? $clog2(CT_B) : 1;
  localparam int CK_W = (NUM_CTXT > 1) ? $clog2(NUM_CTXT) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] S_ID1  = 3'd2;
  localparam logic [2:0] S_ID2  = 3'd3;
  localparam logic [2:0] S_CTXT = 3'd4;
  localparam logic [2:0] S_GID  = 3'd5;

  localparam logic [1:0] T_AND = 2'd0;
  localparam logic [1:0] T_BUF = 2'd2;

  logic [2:0]                 state;
  logic [1:0]                 type_q;
  logic [ID_W-1:0]            id1_q;
  logic [ID_W-1:0]            id2_q;
  logic [ID_W-1:0]            gid_q;
  logic [NUM_CTXT*CTXT_W-1:0] ctxt_q;
  logic [BI_W-1:0]            byte_idx;
  // ctxt_cnt = {ctxt_k, ctxt_b}: ciphertext index and byte within it
  logic [CK_W-1:0]            ctxt_k;
  logic [CB_W-1:0]            ctxt_b;
  logic                       out_valid_q;
  logic                       done_q;
  logic [7:0]                 out_data_c;

  logic hs;
  logic last_id;
  logic last_cb;
  logic last_ck;

  assign hs      = out_valid_q && bus.out_ready;
  assign last_id = (byte_idx == BI_W'(ID_B - 1));
  assign last_cb = (ctxt_b == CB_W'(CT_B - 1));
  assign last_ck = (ctxt_k == CK_W'(NUM_CTXT - 1));

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign bus.out_data  = out_data_c;

  // Byte mux is driven from registered state/counters only, so out_data
  // holds naturally while the consumer stalls.
  always_comb begin
    out_data_c = 8'h00;
    case (state)
      S_TYPE:  out_data_c = {6'b0, type_q};
      S_ID1:   out_data_c = id1_q[8*byte_idx +: 8];
      S_ID2:   out_data_c = id2_q[8*byte_idx +: 8];
      S_CTXT:  out_data_c = ctxt_q[8*(int'(ctxt_k)*CT_B + int'(ctxt_b)) +: 8];
      S_GID:   out_data_c = gid_q[8*byte_idx +: 8];
      default: out_data_c = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      type_q      <= '0;
      id1_q       <= '0;
      id2_q       <= '0;
      gid_q       <= '0;
      ctxt_q      <= '0;
      byte_idx    <= '0;
      ctxt_k      <= '0;
      ctxt_b      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            type_q      <= bus.gate_type;
            id1_q       <= bus.id_1;
            id2_q       <= bus.id_2;
            gid_q       <= bus.gate_id;
            ctxt_q      <= bus.ctxt;
            byte_idx    <= '0;
            ctxt_k      <= '0;
            ctxt_b      <= '0;
            out_valid_q <= 1'b1;
            state       <= S_TYPE;
          end
        end
        S_TYPE: begin
          if (hs) state <= S_ID1;
        end
        S_ID1: begin
          if (hs) begin
            if (last_id) begin
              byte_idx <= '0;
              state    <= (type_q == T_BUF) ? S_GID : S_ID2;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        S_ID2: begin
          if (hs) begin
            if (last_id) begin
              byte_idx <= '0;
              // reserved type 3 falls through like XOR
              state    <= (type_q == T_AND) ? S_CTXT : S_GID;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        S_CTXT: begin
          if (hs) begin
            if (last_cb) begin
              ctxt_b <= '0;
              if (last_ck) begin
                ctxt_k <= '0;
                state  <= S_GID;
              end else begin
                ctxt_k <= ctxt_k + 1'b1;
              end
            end else begin
              ctxt_b <= ctxt_b + 1'b1;
            end
          end
        end
        S_GID: begin
          if (hs) begin
            if (last_id) begin
              byte_idx    <= '0;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state       <= S_IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gate_encoder.sv
module tb_gate_encoder;
  localparam int ID_W     = 24;
  localparam int CTXT_W   = 128;
  localparam int NUM_CTXT = 3;
  localparam int NB       = NUM_CTXT * CTXT_W / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_encoder_if #(.ID_W(ID_W), .CTXT_W(CTXT_W), .NUM_CTXT(NUM_CTXT)) bus ();
  gate_encoder #(.ID_W(ID_W), .CTXT_W(CTXT_W), .NUM_CTXT(NUM_CTXT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [1:0]                 gt;
    logic [ID_W-1:0]            id1;
    logic [ID_W-1:0]            id2;
    logic [ID_W-1:0]            gid;
    logic [NUM_CTXT*CTXT_W-1:0] ct;
    bit                         bp;
    int                         exp_len;
    logic [79:0]                exp_head;   // first 10 bytes, byte 0 in MSBs
  } rec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  byte unsigned got_q[$];
  int           got_cyc[$];
  int           done_cyc[$];
  byte unsigned exp_q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference stream built directly from the field layout rules.
  function automatic void model_append(input rec_t r);
    exp_q.push_back({6'b0, r.gt});
    for (int i = 0; i < ID_W/8; i++) exp_q.push_back(r.id1[8*i +: 8]);
    if (r.gt != 2'd2)
      for (int i = 0; i < ID_W/8; i++) exp_q.push_back(r.id2[8*i +: 8]);
    if (r.gt == 2'd0)
      for (int i = 0; i < NB; i++) exp_q.push_back(r.ct[8*i +: 8]);
    for (int i = 0; i < ID_W/8; i++) exp_q.push_back(r.gid[8*i +: 8]);
  endfunction

  task automatic drive_fields(input rec_t r);
    bus.gate_type = r.gt;
    bus.id_1      = r.id1;
    bus.id_2      = r.id2;
    bus.gate_id   = r.gid;
    bus.ctxt      = r.ct;
  endtask

  // Presents a record for one edge; returns at the negedge after the accept.
  task automatic apply(input rec_t r);
    @(negedge clk);
    drive_fields(r);
    bus.in_valid = 1'b1;
    chk("in_ready_before_accept", {63'b0, bus.in_ready}, 64'd1);
    @(negedge clk);
  endtask

  // Called at a negedge; watches the byte stream until n_done done pulses.
  task automatic collect(input bit bp, input int n_done, input int max_cyc, input bit scramble);
    bit prev_stall = 1'b0;
    bit prev_done  = 1'b0;
    bit finished   = 1'b0;
    logic [7:0] prev_data = 8'h00;
    got_q.delete(); got_cyc.delete(); done_cyc.delete();
    cyc = 0;
    for (int k = 0; k < max_cyc; k++) begin
      cyc++;
      if (k == 0 && scramble) begin
        bus.in_valid  = 1'b0;
        bus.gate_type = 2'($urandom);
        bus.id_1      = ID_W'($urandom);
        bus.id_2      = ID_W'($urandom);
        bus.gate_id   = ID_W'($urandom);
        for (int w = 0; w < NB/4; w++) bus.ctxt[32*w +: 32] = $urandom;
        chk("in_ready_busy", {63'b0, bus.in_ready}, 64'd0);
      end
      if (prev_stall) begin
        chk("hold_data", {56'b0, bus.out_data}, {56'b0, prev_data});
        chk("hold_valid", {63'b0, bus.out_valid}, 64'd1);
      end
      if (bus.done) begin
        done_cyc.push_back(cyc);
        chk("in_ready_on_done", {63'b0, bus.in_ready}, 64'd1);
      end
      if (prev_done) bus.in_valid = 1'b0;
      prev_done = bus.done;
      if (done_cyc.size() >= n_done) begin
        finished = 1'b1;
        break;
      end
      bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        got_cyc.push_back(cyc);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      @(negedge clk);
    end
    if (!finished) begin
      vectors++;
      miscompares++;
      $display("FAIL collect_timeout: got %0d done pulses expected %0d", done_cyc.size(), n_done);
    end
  endtask

  task automatic compare_stream(input string nm);
    chk({nm, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({nm, "_byte"}, {56'b0, got_q[i]}, {56'b0, exp_q[i]});
  endtask

  task automatic run_rec(input rec_t r, input bit use_table);
    apply(r);
    collect(r.bp, 1, 3000, 1'b1);
    exp_q.delete();
    model_append(r);
    compare_stream("stream");
    if (use_table) begin
      chk("table_len", 64'(got_q.size()), 64'(r.exp_len));
      for (int i = 0; i < 10 && i < got_q.size(); i++)
        chk("table_head", {56'b0, got_q[i]}, {56'b0, r.exp_head[79-8*i -: 8]});
    end
    if (got_cyc.size() > 0 && done_cyc.size() > 0) begin
      chk("done_after_last", 64'(done_cyc[0]), 64'(got_cyc[got_cyc.size()-1] + 1));
      if (!r.bp)
        chk("one_byte_per_cycle", 64'(got_cyc[got_cyc.size()-1] - got_cyc[0] + 1),
            64'(got_q.size()));
    end
  endtask

  rec_t tbl[5];
  rec_t r, ra, rb;
  logic [NUM_CTXT*CTXT_W-1:0] ramp;
  int n;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.gate_type = '0; bus.id_1 = '0; bus.id_2 = '0; bus.gate_id = '0; bus.ctxt = '0;
    for (int k = 0; k < NB; k++) ramp[8*k +: 8] = 8'(k);

    tbl[0] = '{2'd2, 24'h123456, 24'h0, 24'hABCDEF, '0, 1'b0, 7,  80'h02563412EFCDAB000000};
    tbl[1] = '{2'd1, 24'h000001, 24'h000002, 24'h000003, '0, 1'b0, 10, 80'h01010000020000030000};
    tbl[2] = '{2'd3, 24'h000001, 24'h000002, 24'h000003, '0, 1'b0, 10, 80'h03010000020000030000};
    tbl[3] = '{2'd0, 24'h000001, 24'h000002, 24'h000003, ramp, 1'b0, 58, 80'h00010000020000000102};
    tbl[4] = '{2'd0, 24'h000001, 24'h000002, 24'h000003, ramp, 1'b1, 58, 80'h00010000020000000102};

    repeat (3) @(negedge clk);
    chk("reset_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("post_reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("post_reset_out_data", {56'b0, bus.out_data}, 64'd0);
    chk("post_reset_done", {63'b0, bus.done}, 64'd0);

    for (int t = 0; t < 5; t++) begin
      run_rec(tbl[t], 1'b1);
      if (tbl[t].gt == 2'd0)
        for (int i = 7; i < 55 && i < got_q.size(); i++)
          chk("and_ctxt_ramp", {56'b0, got_q[i]}, 64'(i - 7));
    end

    // random records with random backpressure
    for (int t = 0; t < 25; t++) begin
      r.gt  = 2'($urandom_range(0, 3));
      r.id1 = ID_W'($urandom);
      r.id2 = ID_W'($urandom);
      r.gid = ID_W'($urandom);
      for (int w = 0; w < NB/4; w++) r.ct[32*w +: 32] = $urandom;
      r.bp = 1'($urandom_range(0, 1));
      r.exp_len = 0;
      r.exp_head = '0;
      run_rec(r, 1'b0);
    end

    // reset in the middle of an AND record
    r = tbl[3];
    apply(r);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 100 && n < 20; k++) begin
      if (bus.out_valid) n++;
      if (n < 20) @(negedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("abort_done", {63'b0, bus.done}, 64'd0);
    chk("abort_out_data", {56'b0, bus.out_data}, 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_quiet_valid", {63'b0, bus.out_valid}, 64'd0);
      chk("abort_quiet_done", {63'b0, bus.done}, 64'd0);
    end
    run_rec(tbl[0], 1'b1);

    // back-to-back: in_valid held high, second record queued behind the first
    ra = tbl[0];
    rb = tbl[1];
    @(negedge clk);
    drive_fields(ra);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    drive_fields(rb);
    collect(1'b0, 2, 200, 1'b0);
    exp_q.delete();
    model_append(ra);
    model_append(rb);
    compare_stream("b2b");
    chk("b2b_done_count", 64'(done_cyc.size()), 64'd2);
    if (done_cyc.size() == 2 && got_q.size() > 7) begin
      chk("b2b_second_start", 64'(got_cyc[7]), 64'(done_cyc[0] + 1));
      chk("b2b_second_done", 64'(done_cyc[1]), 64'(got_cyc[got_cyc.size()-1] + 1));
    end
    @(negedge clk);
    chk("b2b_idle_after", {63'b0, bus.out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gate_encoder.md
Name: gate_encoder

Overview:
- Serializes one parallel gate record into the byte stream consumed by `spi_decoder`; byte-for-byte the inverse of that decoder.
- Used on the host-emulation/loopback path and in test harnesses to feed the SPI byte interface from parallel gate records.
- Holds one record at a time and emits it under a valid/ready byte handshake toward the SPI transmit shifter.

Parameters:
ID_W, 24, width of id_1/id_2/gate_id in bits; multiple of 8; ID_B = ID_W/8 bytes per id
CTXT_W, 128, width of one ciphertext in bits; multiple of 8; CT_B = CTXT_W/8 bytes per ctxt
NUM_CTXT, 3, number of ciphertexts sent for an AND gate

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  record present on the in_* fields
in_ready  out  1  encoder idle and able to accept a record
gate_type  in  2  0=AND, 1=XOR, 2=BUF, 3=reserved
id_1  in  ID_W  first input wire id
id_2  in  ID_W  second input wire id; ignored for BUF
ctxt  in  NUM_CTXT*CTXT_W  ciphertexts; ctxt index k occupies bits [k*CTXT_W +: CTXT_W]; used only for AND
gate_id  in  ID_W  output storage id
out_data  out  8  current byte
out_valid  out  1  out_data valid
out_ready  in  1  byte consumer accepts out_data
done  out  1  one-cycle pulse after the last byte of a record is accepted

Behaviour:
- in_ready = (state == IDLE), combinational. Accept occurs on a clock edge with in_valid && in_ready; all in_* fields are latched on that edge.
- FSM states: IDLE, TYPE, ID1, ID2, CTXT, GID.
- Counters: byte_idx counts bytes within a field. ctxt_cnt holds {ctxt index, byte index} while in CTXT.
- Byte advance: occurs only on an edge with out_valid && out_ready. While out_ready is low, out_data and out_valid hold stable.
- Stream order, all multi-byte fields least-significant byte first:
  - TYPE: one byte, {6'b0, gate_type}.
  - ID1: ID_B bytes of id_1.
  - ID2: ID_B bytes of id_2. Skipped for BUF.
  - CTXT: ctxt 0 bytes 0..CT_B-1, then ctxt 1, up to ctxt NUM_CTXT-1. Sent for AND only.
  - GID: ID_B bytes of gate_id.
- Transitions:
  - IDLE→TYPE on accept.
  - TYPE→ID1 after its byte.
  - ID1→GID if BUF, else →ID2.
  - ID2→CTXT if AND, else →GID. Type 3 follows the XOR layout, matching the decoder.
  - CTXT→GID after byte CT_B-1 of ctxt NUM_CTXT-1.
  - GID→IDLE after its last byte.
- byte_idx clears on every field change.
- Record lengths with defaults: BUF 7 bytes, XOR/reserved 10 bytes, AND 58 bytes.
- Latency and timing:
  - out_valid rises the cycle after accept. out_valid is registered and deasserts only in IDLE.
  - With out_ready held high, one byte is transferred per cycle.
  - done is high for exactly the cycle after the final byte handshake; that same cycle in_ready=1.
  - Minimum gap between records is one cycle (the IDLE cycle).
- in_* changes after accept have no effect on the record in flight. in_valid asserted while busy is ignored (not accepted).
- Reset values: state IDLE, out_valid 0, out_data 8'h00, done 0, all counters 0.
  - Reset asserted mid-record aborts it immediately: no further bytes are emitted and no done pulse occurs.
  - in_ready=1 in the first cycle after rst deasserts.
- out_data in IDLE is 8'h00.

Test Plan:
- BUF: gate_type=2, id_1=0x123456, gate_id=0xABCDEF, out_ready=1 → bytes 02 56 34 12 EF CD AB on consecutive cycles, done on the cycle after EF..AB completes, 7 bytes total.
- XOR: type=1, id_1=0x000001, id_2=0x000002, gate_id=0x000003 → 01 01 00 00 02 00 00 03 00 00 (10 bytes). Repeat with type=3 → same layout, first byte 03.
- AND: ctxt byte k = k (0..47), ids as above → 58 bytes. Bytes 7..54 equal 0x00..0x2F. Feed the stream into spi_decoder and check:
  - gate_type, input_id, ctxt and gate_id outputs match.
  - ctxt_idx sequence 0,1,2.
  - Three ctxt_strobe pulses.
- Backpressure: AND record with out_ready toggled pseudo-randomly (about 50%) → identical 58-byte sequence, no byte duplicated or dropped, out_data stable whenever out_valid && !out_ready.
- Reset mid-operation: assert rst after 20 bytes of an AND record → out_valid=0 the next cycle, no done pulse. A following BUF record is emitted correctly from its type byte.
- Back-to-back: in_valid held high with two queued records → second accepted in the done cycle, first byte of the second record appears the following cycle, in_valid ignored while busy.
